// File: rtl/sll_iter_pkg.sv
// -----------------------------------------------------------------------------
// sll_iter_pkg
// Shared ALU definitions for the iterative left shifter: datapath constants
// and the control state encoding.
// -----------------------------------------------------------------------------
package sll_iter_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage : sll_iter_pkg

// File: rtl/sll_iter_sl_2b.sv
// -----------------------------------------------------------------------------
// sl_2b
// Combinational 2-bit logical left shift with zero fill.
// Ports:
//   in_i  [WIDTH-1:0]  value to shift
//   out_o [WIDTH-1:0]  in_i << 2, low two bits zero
// -----------------------------------------------------------------------------
module sl_2b #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] out_o
);

  assign out_o = {in_i[WIDTH-3:0], 2'b00};

endmodule : sl_2b

// File: rtl/sll_iter.sv
// -----------------------------------------------------------------------------
// sll_iter
// Multi-cycle logical left shifter. Accepts an operand and shift amount over
// a valid/ready handshake, shifts by up to 2 bits per cycle in a registered
// accumulator, and returns the result over a second valid/ready handshake.
// Ports:
//   clock, reset_n          clock, synchronous active-low reset
//   in_valid / in_ready     input handshake
//   data_operandA [WIDTH]   value to shift
//   ctrl_shiftamt [SHAMT_W] shift amount 0..31
//   out_valid / out_ready   output handshake
//   out [WIDTH]             shifted result (valid while out_valid=1)
//   overflow                signed-overflow flag, only with SLL_OVF_EN
// Optional feature macro: SLL_OVF_EN
// -----------------------------------------------------------------------------
module sll_iter #(
  parameter int WIDTH   = sll_iter_pkg::WIDTH,
  parameter int SHAMT_W = sll_iter_pkg::SHAMT_W
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_operandA,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out
`ifdef SLL_OVF_EN
  ,
  output logic               overflow
`endif
);

  import sll_iter_pkg::*;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0]   acc_sl2;
  logic [WIDTH-1:0]   acc_sl1;
  logic               accept;

`ifdef SLL_OVF_EN
  logic sign_q, sign_d;  // original operand bit 31
  logic ovf_q, ovf_d;
`endif

  sl_2b #(.WIDTH(WIDTH)) u_sl_2b (
    .in_i  (acc_q),
    .out_o (acc_sl2)
  );

  assign acc_sl1 = {acc_q[WIDTH-2:0], 1'b0};

  // Handshake outputs are pure state decodes, so no input reaches an output
  // combinationally.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = acc_q;
  assign accept    = in_ready && in_valid;

`ifdef SLL_OVF_EN
  assign overflow = ovf_q;
`endif

  // NOTE: every combinational output gets a default first so no path through
  // the case statement leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
`ifdef SLL_OVF_EN
    sign_d  = sign_q;
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          acc_d   = data_operandA;
          rem_d   = ctrl_shiftamt;
          state_d = (ctrl_shiftamt == '0) ? DONE : SHIFT;
`ifdef SLL_OVF_EN
          sign_d  = data_operandA[WIDTH-1];
          ovf_d   = 1'b0;
`endif
        end
      end
      SHIFT: begin
        if (rem_q >= SHAMT_W'(2)) begin
          acc_d = acc_sl2;
          rem_d = rem_q - SHAMT_W'(2);
`ifdef SLL_OVF_EN
          // Two bits leave the top and acc[WIDTH-3] becomes the new sign.
          if ((acc_q[WIDTH-1] != sign_q) || (acc_q[WIDTH-2] != sign_q) ||
              (acc_q[WIDTH-3] != sign_q))
            ovf_d = 1'b1;
`endif
        end else begin
          acc_d = acc_sl1;
          rem_d = '0;
`ifdef SLL_OVF_EN
          if ((acc_q[WIDTH-1] != sign_q) || (acc_q[WIDTH-2] != sign_q))
            ovf_d = 1'b1;
`endif
        end
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
`ifdef SLL_OVF_EN
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
`ifdef SLL_OVF_EN
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule : sll_iter

// File: tb/tb_sll_iter.sv
// -----------------------------------------------------------------------------
// tb_sll_iter
// Directed self-checking bench for sll_iter. Overflow checks are compiled in
// when SLL_OVF_EN is defined.
// -----------------------------------------------------------------------------
module tb_sll_iter;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_operandA;
  logic [4:0]  ctrl_shiftamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
`ifdef SLL_OVF_EN
  logic        overflow;
`endif

  int checks = 0;
  int errors = 0;

  sll_iter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .data_operandA (data_operandA),
    .ctrl_shiftamt (ctrl_shiftamt),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (out)
`ifdef SLL_OVF_EN
    ,
    .overflow      (overflow)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called at a negedge with the block idle. Runs one operation, checks the
  // result and latency, optionally stalls the consumer for 'stall' cycles
  // while poking in_valid, then completes the output handshake and returns
  // at the negedge of the cycle after it.
  task automatic run_op(input logic [31:0] a, input logic [4:0] amt,
                        input int stall, input logic [31:0] exp_out);
    int lat;
    int exp_lat;
    logic [31:0] held;
    exp_lat = 1 + (int'(amt) + 1) / 2;
    check("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    data_operandA = a;
    ctrl_shiftamt = amt;
    out_ready     = (stall == 0);
    @(posedge clock);
    #1;
    in_valid      = 1'b0;
    data_operandA = $urandom;
    ctrl_shiftamt = 5'($urandom);
    lat = 1;
    @(negedge clock);
    while (out_valid !== 1'b1 && lat < 40) begin
      @(negedge clock);
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("out", out, exp_out);
`ifdef SLL_OVF_EN
    check("overflow", {31'd0, overflow},
          {31'd0, (($signed(exp_out) >>> amt) != $signed(a))});
`endif
    held = out;
    for (int i = 0; i < stall; i++) begin
      in_valid      = 1'b1;
      data_operandA = $urandom;
      ctrl_shiftamt = 5'($urandom);
      @(negedge clock);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_stable", out, held);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [4:0]  amt;
    int          stale;

    reset_n       = 1'b0;
    in_valid      = 1'b0;
    out_ready     = 1'b0;
    data_operandA = '0;
    ctrl_shiftamt = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out", out, 32'h0);
`ifdef SLL_OVF_EN
    check("reset_overflow", {31'd0, overflow}, 32'd0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    // Directed vectors with hand-computed results.
    run_op(32'h0000_0001, 5'd0,  0, 32'h0000_0001);
    run_op(32'h8000_0001, 5'd31, 0, 32'h8000_0000);
    run_op(32'h0000_00F0, 5'd5,  0, 32'h0000_1E00);
    run_op(32'h4000_0000, 5'd1,  5, 32'h8000_0000);
    run_op(32'hDEAD_BEEF, 5'd2,  0, 32'h7AB6_FBBC);
    run_op(32'hFFFF_FFFF, 5'd16, 2, 32'hFFFF_0000);
    run_op(32'h1234_5678, 5'd4,  0, 32'h2345_6780);
    run_op(32'hFFFF_FFFF, 5'd30, 1, 32'hC000_0000);

    // Random operands back to back with random consumer stalls.
    for (int i = 0; i < 16; i++) begin
      a   = $urandom;
      amt = 5'($urandom_range(0, 31));
      run_op(a, amt, int'($urandom_range(0, 3)), a << amt);
    end

    // Reset in cycle 3 of an amount-20 operation.
    check("pre_reset_in_ready", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    data_operandA = 32'h0000_0ABC;
    ctrl_shiftamt = 5'd20;
    out_ready     = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out", out, 32'h0);
    reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (out_valid === 1'b1) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);

    // Normal operation resumes after the abort.
    run_op(32'h0000_0003, 5'd3, 0, 32'h0000_0018);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_sll_iter

// File: doc/sll_iter.md
# sll_iter

Multi-cycle logical left shifter for the ALU shift path and the left-hand counterpart of the existing right-shift stages. It accepts one operand and a 5-bit shift amount over a valid/ready handshake and shifts left by at most 2 bits per cycle through a registered datapath. It returns the result over a second valid/ready handshake. It serves as the low-area alternative to the full combinational left barrel shifter in the execute stage.

## Interface
- `WIDTH`, default 32: operand and result width. Only 32 is supported.
- `SHAMT_W`, default 5: shift-amount width, equal to log2(WIDTH).
- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clock`.
- `in_valid`  in  1  operand and amount presented.
- `in_ready`  out  1  block can accept an operation.
- `data_operandA`  in  WIDTH  value to shift.
- `ctrl_shiftamt`  in  SHAMT_W  shift amount, 0–31.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out`  out  WIDTH  shifted result.
- `overflow`  out  1  signed-overflow flag. This port exists only with `SLL_OVF_EN`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - SHIFT: shifting; `in_ready`=0.
  - DONE: `out_valid`=1.
- Transitions:
  - IDLE → SHIFT on `in_valid`&`in_ready` with amount ≠ 0. Latch the operand into `acc` and the amount into `rem`.
  - IDLE → DONE on an accept with amount = 0. `acc` = operand.
  - In SHIFT, each cycle:
    - If `rem`≥2: `acc` ← `acc`<<2 with zero fill, and `rem` ← `rem`−2.
    - If `rem`=1: `acc` ← `acc`<<1 and `rem` ← 0.
    - Move to DONE when the updated `rem` = 0.
  - DONE → IDLE on `out_valid`&`out_ready`.
  - DONE holds `out` and `overflow` stable while `out_ready`=0.
- `out` always reflects `acc`. Its value is defined only while `out_valid`=1.
- Bits shifted past bit 31 are discarded; the shift is logical (zero fill).
- Inputs other than `in_valid` are ignored outside IDLE. A new accept is possible only in the cycle after the output handshake; there is no same-cycle turnaround.
- Reset values: state IDLE, `acc`=0, `rem`=0, `in_ready`=1, `out_valid`=0, `out`=0, `overflow`=0.
- Reset mid-operation (state SHIFT or DONE) aborts the operation. The pending result is dropped and no `out_valid` pulse follows.

## Timing
- Accept in cycle 0.
- Number of shift cycles = ceil(amt/2).
- `out_valid` rises at the start of cycle 1+ceil(amt/2):
  - amt 0 → cycle 1.
  - amt 1 → cycle 2.
  - amt 31 → cycle 17.
- Throughput: one operation per (2 + ceil(amt/2)) cycles when `out_ready` is held at 1.
- All outputs are registered or decoded from state only; there is no combinational path from input to output.

## Configuration
- `SLL_OVF_EN` defined:
  - The `overflow` port and its sticky register are present.
  - The register clears on accept.
  - During SHIFT it sets if any bit shifted out of the top differs from the original bit 31, or if the new `acc[31]` differs from the original bit 31.
  - In DONE it is 1 exactly when (`out` >>> amt) ≠ the original operand.
- `SLL_OVF_EN` undefined: no `overflow` port and no extra registers; the rest of the behaviour is identical.

## Structure
- Shared ALU package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - the constants `WIDTH`=32 and `SHAMT_W`=5.
- Sub-module `sl_2b`: combinational 2-bit logical left shift, `out[i]` = `in[i-2]` and `out[1:0]`=0. The 1-bit step is inline.

## Test plan
- Operand 0x0000_0001, amt 0, `out_ready`=1 → `out`=0x0000_0001 in cycle 1, `in_ready` back high in cycle 2.
- Operand 0x8000_0001, amt 31 → `out`=0x8000_0000 in cycle 17. With `SLL_OVF_EN`, `overflow`=1.
- Operand 0x0000_00F0, amt 5 → `out`=0x0000_1E00 in cycle 4. With `SLL_OVF_EN`, `overflow`=0.
- Operand 0x4000_0000, amt 1, `out_ready` held low for 5 cycles → `out`=0x8000_0000 stays stable, `overflow`=1, and `in_valid` is ignored until the handshake completes.
- `reset_n` low in cycle 3 of an amt-20 operation → next cycle shows state IDLE, `out_valid`=0, `out`=0; no stale result afterwards.
- Random operands and amounts, back-to-back with random `out_ready` → every `out` equals `data_operandA << amt` truncated to 32 bits, and each latency equals 1+ceil(amt/2).
